// File: rtl/csr_addr_fifo.sv
// CSR address FIFO: holds {CSR address, transaction ID} of issued CSR ops in issue order
// and presents the oldest entry to the commit stage until it is retired.
module csr_addr_fifo #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned XLEN       = 64,
  parameter int unsigned TRANS_ID_W = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          valid_i,
  input  logic [XLEN-1:0]               operand_a_i,
  input  logic [XLEN-1:0]               operand_b_i,
  input  logic [TRANS_ID_W-1:0]         trans_id_i,
  output logic                          ready_o,
  output logic [XLEN-1:0]               result_o,
  output logic                          result_valid_o,
  output logic [TRANS_ID_W-1:0]         result_id_o,
  input  logic                          commit_i,
  output logic                          csr_valid_o,
  output logic [11:0]                   csr_addr_o,
  output logic [TRANS_ID_W-1:0]         csr_id_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);

  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned SLOTS = 1 << PW;

  // Handshake: an op is taken when valid_i & ready_o & ~flush_i on a rising edge;
  // an op presented while ready_o is low is not stored and must be held by the issuer.

  logic [11:0]           r_addr [SLOTS];
  logic [TRANS_ID_W-1:0] r_id   [SLOTS];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_ready;
  logic w_unused_b;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_pop      = commit_i & ~w_empty;
  // A commit in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_ready    = (r_count < CW'(DEPTH)) | w_pop;
  assign w_push     = valid_i & w_ready & ~flush_i;
  assign w_unused_b = ^operand_b_i[XLEN-1:12];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        r_addr[i] <= '0;
        r_id[i]   <= '0;
      end
    end else if (flush_i) begin
      // Entry contents are left stale; only the bookkeeping is cleared.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_addr[r_wr_ptr] <= operand_b_i[11:0];
        r_id[r_wr_ptr]   <= trans_id_i;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign ready_o        = w_ready;
  assign result_o       = operand_a_i;
  assign result_valid_o = w_push;
  assign result_id_o    = trans_id_i;

  assign csr_valid_o    = ~w_empty;
  assign csr_addr_o     = r_addr[r_rd_ptr];
  assign csr_id_o       = r_id[r_rd_ptr];
  assign count_o        = r_count;

endmodule

// File: tb/tb_csr_addr_fifo.sv
// Bench for csr_addr_fifo: DEPTH=2, 4 and 1 instances share one stimulus stream and are
// each compared every cycle against a queue-based reference of the FIFO rules.
module tb_csr_addr_fifo;

  typedef logic [14:0] ent_t;
  typedef ent_t ent_q_t[$];

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        commit_i = 1'b0;
  logic [63:0] op_a = '0;
  logic [63:0] op_b = '0;
  logic [2:0]  tid = '0;

  logic        rdy [3];
  logic        rv  [3];
  logic        cv  [3];
  logic [11:0] ca  [3];
  logic [2:0]  cid [3];
  logic [2:0]  rid [3];
  logic [63:0] res [3];
  logic [1:0]  cnt2;
  logic [2:0]  cnt4;
  logic [0:0]  cnt1;
  logic [2:0]  cnt_all [3];

  assign cnt_all[0] = {1'b0, cnt2};
  assign cnt_all[1] = cnt4;
  assign cnt_all[2] = {2'b00, cnt1};

  int     tests  = 0;
  int     failed = 0;
  int     depths [3] = '{2, 4, 1};
  ent_q_t q0, q1, q2;

  always #5 clk_i = ~clk_i;

  csr_addr_fifo #(.DEPTH(2), .XLEN(64), .TRANS_ID_W(3)) u_d2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
    .operand_a_i(op_a), .operand_b_i(op_b), .trans_id_i(tid),
    .ready_o(rdy[0]), .result_o(res[0]), .result_valid_o(rv[0]), .result_id_o(rid[0]),
    .commit_i(commit_i), .csr_valid_o(cv[0]), .csr_addr_o(ca[0]), .csr_id_o(cid[0]),
    .count_o(cnt2));

  csr_addr_fifo #(.DEPTH(4), .XLEN(64), .TRANS_ID_W(3)) u_d4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
    .operand_a_i(op_a), .operand_b_i(op_b), .trans_id_i(tid),
    .ready_o(rdy[1]), .result_o(res[1]), .result_valid_o(rv[1]), .result_id_o(rid[1]),
    .commit_i(commit_i), .csr_valid_o(cv[1]), .csr_addr_o(ca[1]), .csr_id_o(cid[1]),
    .count_o(cnt4));

  csr_addr_fifo #(.DEPTH(1), .XLEN(64), .TRANS_ID_W(3)) u_d1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
    .operand_a_i(op_a), .operand_b_i(op_b), .trans_id_i(tid),
    .ready_o(rdy[2]), .result_o(res[2]), .result_valid_o(rv[2]), .result_id_o(rid[2]),
    .commit_i(commit_i), .csr_valid_o(cv[2]), .csr_addr_o(ca[2]), .csr_id_o(cid[2]),
    .count_o(cnt1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are applied just after a rising edge and allowed to settle before sampling.
  task automatic drive(input logic v, input logic [11:0] addr, input logic [2:0] id,
                       input logic c, input logic f);
    valid_i  = v;
    op_b     = {$urandom(), $urandom()};
    op_b[11:0] = addr;
    op_a     = {$urandom(), $urandom()};
    tid      = id;
    commit_i = c;
    flush_i  = f;
    #3;
  endtask

  // Compares every instance with its reference queue, then applies this cycle's rules.
  task automatic check_and_advance();
    ent_q_t cur;
    int     sz;
    logic   e_pop, e_ready, e_push;
    string  p;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       cur = q0;
        1:       cur = q1;
        default: cur = q2;
      endcase
      p       = $sformatf("d%0d", depths[k]);
      sz      = cur.size();
      e_pop   = commit_i && (sz > 0);
      e_ready = (sz < depths[k]) || e_pop;
      e_push  = valid_i && e_ready && !flush_i;
      chk({p, ".ready"},        64'(rdy[k]),     64'(e_ready));
      chk({p, ".result_valid"}, 64'(rv[k]),      64'(e_push));
      chk({p, ".result"},       res[k],          op_a);
      chk({p, ".result_id"},    64'(rid[k]),     64'(tid));
      chk({p, ".csr_valid"},    64'(cv[k]),      64'(sz > 0));
      chk({p, ".count"},        64'(cnt_all[k]), 64'(sz));
      if (sz > 0) begin
        chk({p, ".csr_addr"}, 64'(ca[k]),  64'(cur[0][14:3]));
        chk({p, ".csr_id"},   64'(cid[k]), 64'(cur[0][2:0]));
      end
      if (flush_i) begin
        cur.delete();
      end else begin
        if (e_pop)  void'(cur.pop_front());
        if (e_push) cur.push_back({op_b[11:0], tid});
      end
      case (k)
        0:       q0 = cur;
        1:       q1 = cur;
        default: q2 = cur;
      endcase
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic step(input logic v, input logic [11:0] addr, input logic [2:0] id,
                      input logic c, input logic f);
    drive(v, addr, id, c, f);
    check_and_advance();
  endtask

  task automatic idle();
    drive(1'b0, 12'h000, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    idle();
    for (int k = 0; k < 3; k++) begin
      chk("reset.csr_valid", 64'(cv[k]),      64'd0);
      chk("reset.csr_addr",  64'(ca[k]),      64'd0);
      chk("reset.csr_id",    64'(cid[k]),     64'd0);
      chk("reset.count",     64'(cnt_all[k]), 64'd0);
      chk("reset.ready",     64'(rdy[k]),     64'd1);
    end
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single issue becomes visible the next cycle
    step(1'b1, 12'h300, 3'd1, 1'b0, 1'b0);
    idle();
    chk("t1.csr_valid", 64'(cv[0]),  64'd1);
    chk("t1.csr_addr",  64'(ca[0]),  64'h300);
    chk("t1.csr_id",    64'(cid[0]), 64'd1);
    chk("t1.count",     64'(cnt2),   64'd1);
    chk("t1.ready",     64'(rdy[0]), 64'd1);

    // Fill DEPTH=2, drop an op while full, then commit
    step(1'b1, 12'h341, 3'd2, 1'b0, 1'b0);
    idle();
    chk("t2.count_full", 64'(cnt2),   64'd2);
    chk("t2.ready_full", 64'(rdy[0]), 64'd0);
    drive(1'b1, 12'h342, 3'd3, 1'b0, 1'b0);
    chk("t2.dropped", 64'(rv[0]), 64'd0);
    check_and_advance();
    step(1'b0, 12'h000, 3'd0, 1'b1, 1'b0);
    idle();
    chk("t2.head_addr", 64'(ca[0]),  64'h341);
    chk("t2.head_id",   64'(cid[0]), 64'd2);
    chk("t2.count",     64'(cnt2),   64'd1);

    // Full plus commit plus issue in the same cycle
    step(1'b1, 12'h310, 3'd4, 1'b0, 1'b0);
    drive(1'b1, 12'h305, 3'd3, 1'b1, 1'b0);
    chk("t3.ready",        64'(rdy[0]), 64'd1);
    chk("t3.result_valid", 64'(rv[0]),  64'd1);
    check_and_advance();
    idle();
    chk("t3.count",     64'(cnt2),  64'd2);
    chk("t3.head_addr", 64'(ca[0]), 64'h310);
    step(1'b0, 12'h000, 3'd0, 1'b1, 1'b0);
    idle();
    chk("t3.next_head", 64'(ca[0]), 64'h305);

    // Flush with three entries in DEPTH=4 while an op is offered
    step(1'b1, 12'h320, 3'd5, 1'b0, 1'b0);
    idle();
    chk("t5.pre_count", 64'(cnt4), 64'd3);
    drive(1'b1, 12'h333, 3'd6, 1'b0, 1'b1);
    chk("t5.result_valid_d4", 64'(rv[1]), 64'd0);
    chk("t5.result_valid_d2", 64'(rv[0]), 64'd0);
    check_and_advance();
    idle();
    chk("t5.count",     64'(cnt4),  64'd0);
    chk("t5.csr_valid", 64'(cv[1]), 64'd0);
    step(1'b0, 12'h000, 3'd0, 1'b1, 1'b0);
    idle();
    chk("t5.commit_empty", 64'(cnt4), 64'd0);

    // DEPTH=1: issue, stall, commit with issue in the same cycle
    step(1'b1, 12'h7c0, 3'd5, 1'b0, 1'b0);
    drive(1'b1, 12'h7c1, 3'd6, 1'b0, 1'b0);
    chk("t6.stall_ready", 64'(rdy[2]), 64'd0);
    check_and_advance();
    drive(1'b1, 12'h7c2, 3'd7, 1'b1, 1'b0);
    chk("t6.swap_ready", 64'(rdy[2]), 64'd1);
    chk("t6.swap_rv",    64'(rv[2]),  64'd1);
    check_and_advance();
    idle();
    chk("t6.head", 64'(ca[2]), 64'h7c2);

    // Wrap: ten pushes interleaved with commits
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 12'h200 + 12'(i), 3'(i), 1'(i % 2), 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 12'h000, 3'd0, 1'b1, 1'b0);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) < 7), 12'($urandom()), 3'($urandom()),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step(1'b1, 12'h0a0 + 12'(i), 3'(i), 1'b0, 1'b0);
    idle();
    rst_ni = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("areset.count",     64'(cnt_all[k]), 64'd0);
      chk("areset.csr_valid", 64'(cv[k]),      64'd0);
      chk("areset.csr_addr",  64'(ca[k]),      64'd0);
    end
    q0.delete();
    q1.delete();
    q2.delete();
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 100; i++) begin
      step(1'($urandom_range(0, 1)), 12'($urandom()), 3'($urandom()),
           1'($urandom_range(0, 3) != 0), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
